// File: rtl/fir_pkg.sv
// Shared types and helpers for the streaming FIR MAC.
package fir_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MAC  = 2'd1,
    OUT  = 2'd2
  } state_t;

  // Wide working width for the output formatter; covers any sane ACC_W/OUT_W
  localparam int unsigned FMT_W = 128;

  typedef struct packed {
    logic                    sat;
    logic signed [FMT_W-1:0] data;
  } fmt_t;

  // Ceiling log2, minimum 1 so a 2-tap filter still gets a 1-bit index
  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 1;
    while ((64'd1 << r) < 64'(n)) r = r + 1;
    return r;
  endfunction

  // Accumulator width that cannot overflow over ntaps full-precision products
  function automatic int unsigned acc_width(input int unsigned dw,
                                            input int unsigned cw,
                                            input int unsigned ntaps);
    return dw + cw + clog2(ntaps);
  endfunction

  // Round, arithmetic shift, then saturate or wrap to out_w bits (sign-extended)
  function automatic fmt_t fmt_output(input logic signed [FMT_W-1:0] acc,
                                      input int unsigned             shift,
                                      input bit                      round,
                                      input bit                      saturate,
                                      input int unsigned             out_w);
    fmt_t                    r;
    logic signed [FMT_W-1:0] v;
    logic signed [FMT_W-1:0] hi;
    logic signed [FMT_W-1:0] lo;
    v = acc;
    if (round && (shift > 0)) v = v + (FMT_W'(1) <<< (shift - 1));
    v  = v >>> shift;
    hi = (FMT_W'(1) <<< (out_w - 1)) - FMT_W'(1);
    lo = -hi - FMT_W'(1);
    r.sat = 1'b0;
    if (saturate) begin
      if (v > hi) begin
        v     = hi;
        r.sat = 1'b1;
      end else if (v < lo) begin
        v     = lo;
        r.sat = 1'b1;
      end
    end else begin
      v = (v <<< (FMT_W - out_w)) >>> (FMT_W - out_w);
    end
    r.data = v;
    return r;
  endfunction

endpackage

// File: rtl/fir_coef_bank.sv
// NTAPS x COEF_W coefficient register file with one write port and a combinational read.
module fir_coef_bank
  import fir_pkg::*;
#(
  parameter int unsigned COEF_W = 16,
  parameter int unsigned NTAPS  = 15
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     i_we,
  input  logic [clog2(NTAPS)-1:0]  i_waddr,
  input  logic signed [COEF_W-1:0] i_wdata,
  input  logic [clog2(NTAPS)-1:0]  i_raddr,
  output logic signed [COEF_W-1:0] o_rdata_c
);

  logic signed [COEF_W-1:0] r_coef [NTAPS];

  // Coefficient write; addresses beyond the last tap are ignored
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned k = 0; k < NTAPS; k++) r_coef[k] <= '0;
    end else if (i_we && (32'(i_waddr) < NTAPS)) begin
      r_coef[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata_c = r_coef[i_raddr];

endmodule

// File: rtl/axis_fir_mac.sv
// AXI-Stream FIR filter: one time-multiplexed MAC, NTAPS cycles per output sample.
module axis_fir_mac
  import fir_pkg::*;
#(
  parameter int unsigned DATA_W   = 16,
  parameter int unsigned COEF_W   = 16,
  parameter int unsigned NTAPS    = 15,
  parameter int unsigned OUT_W    = 32,
  parameter int unsigned SHIFT    = 0,
  parameter int unsigned ROUND    = 1,
  parameter int unsigned SATURATE = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic signed [DATA_W-1:0] s_axis_tdata,
  input  logic                     s_axis_tvalid,
  input  logic                     s_axis_tlast,
  output logic                     s_axis_tready,
  output logic signed [OUT_W-1:0]  m_axis_tdata,
  output logic                     m_axis_tvalid,
  output logic                     m_axis_tlast,
  input  logic                     m_axis_tready,
  input  logic                     coef_we,
  input  logic [clog2(NTAPS)-1:0]  coef_addr,
  input  logic signed [COEF_W-1:0] coef_wdata,
  output logic                     coef_ready,
  output logic                     sat_sticky,
  input  logic                     sat_clr
);

  localparam int unsigned TAP_W  = clog2(NTAPS);
  localparam int unsigned PROD_W = DATA_W + COEF_W;
  localparam int unsigned ACC_W  = acc_width(DATA_W, COEF_W, NTAPS);

  state_t                    r_state;
  state_t                    w_state_nxt;
  logic                      w_accept;
  logic                      w_load;
  logic signed [DATA_W-1:0]  r_x [NTAPS];
  logic signed [ACC_W-1:0]   r_acc;
  logic [TAP_W-1:0]          r_tap;
  logic                      r_last;
  logic                      r_rdy;
  logic                      r_m_valid;
  logic [OUT_W-1:0]          r_m_data;
  logic                      r_m_last;
  logic                      r_sat;
  logic signed [COEF_W-1:0]  w_coef;
  logic signed [PROD_W-1:0]  w_prod;
  logic signed [ACC_W-1:0]   w_acc_sum;
  logic [OUT_W:0]            w_fmt;

  // Formatter result packed as {saturated, data[OUT_W-1:0]}
  function automatic logic [OUT_W:0] fmt_pack(input logic signed [ACC_W-1:0] a);
    fmt_t f;
    f = fmt_output(FMT_W'(a), SHIFT, ROUND != 0, SATURATE != 0, OUT_W);
    return {f.sat, f.data[OUT_W-1:0]};
  endfunction

  fir_coef_bank #(
    .COEF_W (COEF_W),
    .NTAPS  (NTAPS)
  ) u_coef_bank (
    .clk       (clk),
    .reset     (reset),
    .i_we      (coef_we && r_rdy),
    .i_waddr   (coef_addr),
    .i_wdata   (coef_wdata),
    .i_raddr   (r_tap),
    .o_rdata_c (w_coef)
  );

  assign w_prod    = PROD_W'(w_coef) * PROD_W'(r_x[r_tap]);
  assign w_acc_sum = r_acc + ACC_W'(w_prod);
  assign w_fmt     = fmt_pack(w_acc_sum);

  // FSM state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state and datapath strobes
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_load      = 1'b0;
    case (r_state)
      IDLE: begin
        if (s_axis_tvalid) begin
          w_accept    = 1'b1;
          w_state_nxt = MAC;
        end
      end
      MAC: begin
        if (r_tap == TAP_W'(NTAPS - 1)) begin
          w_load      = 1'b1;
          w_state_nxt = OUT;
        end
      end
      OUT: begin
        if (m_axis_tready) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Delay line, MAC accumulator, output register and status flags
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned k = 0; k < NTAPS; k++) r_x[k] <= '0;
      r_acc     <= '0;
      r_tap     <= '0;
      r_last    <= 1'b0;
      r_rdy     <= 1'b1;
      r_m_valid <= 1'b0;
      r_m_data  <= '0;
      r_m_last  <= 1'b0;
      r_sat     <= 1'b0;
    end else begin
      if (w_accept) begin
        for (int unsigned k = 1; k < NTAPS; k++) r_x[k] <= r_x[k-1];
        r_x[0] <= s_axis_tdata;
        r_last <= s_axis_tlast;
        r_acc  <= '0;
        r_tap  <= '0;
      end else if (r_state == MAC) begin
        r_acc <= w_acc_sum;
        r_tap <= r_tap + TAP_W'(1);
      end
      if (w_load) begin
        r_m_data <= w_fmt[OUT_W-1:0];
        r_m_last <= r_last;
      end
      // A saturation on the loading edge beats a same-cycle clear
      if (w_load && w_fmt[OUT_W]) r_sat <= 1'b1;
      else if (sat_clr)           r_sat <= 1'b0;
      r_rdy     <= (w_state_nxt == IDLE);
      r_m_valid <= (w_state_nxt == OUT);
    end
  end

  assign s_axis_tready = r_rdy;
  assign coef_ready    = r_rdy;
  assign m_axis_tvalid = r_m_valid;
  assign m_axis_tdata  = r_m_data;
  assign m_axis_tlast  = r_m_last;
  assign sat_sticky    = r_sat;

endmodule

// File: tb/tb_axis_fir_mac.sv
// Directed bench for axis_fir_mac: five parameterisations share one stimulus.
module tb_axis_fir_mac;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] s_tdata;
  logic        s_tvalid;
  logic        s_tlast;
  logic        m_tready;
  logic        coef_we;
  logic [3:0]  coef_addr;
  logic [15:0] coef_wdata;
  logic        sat_clr;

  // 0: defaults, 1: OUT_W=16 sat, 2: OUT_W=16 wrap, 3: SHIFT=15 round, 4: SHIFT=15 no round
  logic        s_rdy  [5];
  logic        c_rdy  [5];
  logic        m_vld  [5];
  logic        m_lst  [5];
  logic        sticky [5];
  logic [31:0] d32    [3];
  logic [15:0] d16    [2];

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int last_acc;
  int last_out;
  logic [31:0] g_main, g_rnd, g_rnf;
  logic [15:0] g_sat, g_trn;
  logic        g_last;
  int          acc_t [15];
  int          out_t [15];
  logic [31:0] out_d [15];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  axis_fir_mac u_main (
    .clk(clk), .reset(rst_n),
    .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid), .s_axis_tlast(s_tlast), .s_axis_tready(s_rdy[0]),
    .m_axis_tdata(d32[0]), .m_axis_tvalid(m_vld[0]), .m_axis_tlast(m_lst[0]), .m_axis_tready(m_tready),
    .coef_we(coef_we), .coef_addr(coef_addr), .coef_wdata(coef_wdata), .coef_ready(c_rdy[0]),
    .sat_sticky(sticky[0]), .sat_clr(sat_clr));

  axis_fir_mac #(.OUT_W(16), .SATURATE(1)) u_sat (
    .clk(clk), .reset(rst_n),
    .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid), .s_axis_tlast(s_tlast), .s_axis_tready(s_rdy[1]),
    .m_axis_tdata(d16[0]), .m_axis_tvalid(m_vld[1]), .m_axis_tlast(m_lst[1]), .m_axis_tready(m_tready),
    .coef_we(coef_we), .coef_addr(coef_addr), .coef_wdata(coef_wdata), .coef_ready(c_rdy[1]),
    .sat_sticky(sticky[1]), .sat_clr(sat_clr));

  axis_fir_mac #(.OUT_W(16), .SATURATE(0)) u_trn (
    .clk(clk), .reset(rst_n),
    .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid), .s_axis_tlast(s_tlast), .s_axis_tready(s_rdy[2]),
    .m_axis_tdata(d16[1]), .m_axis_tvalid(m_vld[2]), .m_axis_tlast(m_lst[2]), .m_axis_tready(m_tready),
    .coef_we(coef_we), .coef_addr(coef_addr), .coef_wdata(coef_wdata), .coef_ready(c_rdy[2]),
    .sat_sticky(sticky[2]), .sat_clr(sat_clr));

  axis_fir_mac #(.SHIFT(15), .ROUND(1)) u_rnd (
    .clk(clk), .reset(rst_n),
    .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid), .s_axis_tlast(s_tlast), .s_axis_tready(s_rdy[3]),
    .m_axis_tdata(d32[1]), .m_axis_tvalid(m_vld[3]), .m_axis_tlast(m_lst[3]), .m_axis_tready(m_tready),
    .coef_we(coef_we), .coef_addr(coef_addr), .coef_wdata(coef_wdata), .coef_ready(c_rdy[3]),
    .sat_sticky(sticky[3]), .sat_clr(sat_clr));

  axis_fir_mac #(.SHIFT(15), .ROUND(0)) u_rnf (
    .clk(clk), .reset(rst_n),
    .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid), .s_axis_tlast(s_tlast), .s_axis_tready(s_rdy[4]),
    .m_axis_tdata(d32[2]), .m_axis_tvalid(m_vld[4]), .m_axis_tlast(m_lst[4]), .m_axis_tready(m_tready),
    .coef_we(coef_we), .coef_addr(coef_addr), .coef_wdata(coef_wdata), .coef_ready(c_rdy[4]),
    .sat_sticky(sticky[4]), .sat_clr(sat_clr));

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic rst_pulse();
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic wr_coef(input logic [3:0] a, input logic [15:0] d);
    coef_we    = 1'b1;
    coef_addr  = a;
    coef_wdata = d;
    @(negedge clk);
    coef_we    = 1'b0;
  endtask

  // Present one sample from a negedge; returns at the negedge after its handshake
  task automatic send(input logic [15:0] d, input logic l);
    int n;
    s_tdata  = d;
    s_tlast  = l;
    s_tvalid = 1'b1;
    n = 0;
    while (!s_rdy[0] && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("send_ready", 64'(s_rdy[0]), 64'(1));
    last_acc = cyc;
    @(negedge clk);
    s_tvalid = 1'b0;
  endtask

  // Take one output with tready high; captures every instance's data
  task automatic recv();
    int n;
    m_tready = 1'b1;
    n = 0;
    while (!m_vld[0] && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("recv_valid", 64'(m_vld[0]), 64'(1));
    g_main   = d32[0];
    g_rnd    = d32[1];
    g_rnf    = d32[2];
    g_sat    = d16[0];
    g_trn    = d16[1];
    g_last   = m_lst[0];
    last_out = cyc;
    @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst_n = 1'b0; s_tdata = '0; s_tvalid = 1'b0; s_tlast = 1'b0; m_tready = 1'b1;
    coef_we = 1'b0; coef_addr = '0; coef_wdata = '0; sat_clr = 1'b0;
    @(negedge clk);
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      chk("rst_srdy", 64'(s_rdy[i]), 64'(1));
      chk("rst_crdy", 64'(c_rdy[i]), 64'(1));
      chk("rst_vld", 64'(m_vld[i]), 64'(0));
      chk("rst_last", 64'(m_lst[i]), 64'(0));
      chk("rst_sticky", 64'(sticky[i]), 64'(0));
    end
    chk("rst_data", 64'(d32[0]), 64'(0));
    rst_n = 1'b1;
    @(negedge clk);

    // Impulse response through c[i]=i+1
    for (int i = 0; i < 15; i++) wr_coef(4'(i), 16'(i + 1));
    fork
      begin
        for (int i = 0; i < 15; i++) begin
          send((i == 0) ? 16'd1 : 16'd0, 1'b0);
          acc_t[i] = last_acc;
        end
      end
      begin
        for (int j = 0; j < 15; j++) begin
          recv();
          out_d[j] = g_main;
          out_t[j] = last_out;
        end
      end
    join
    for (int i = 0; i < 15; i++) chk("imp_y", 64'(out_d[i]), 64'(i + 1));
    chk("imp_latency", 64'(out_t[0] - acc_t[0]), 64'(16));
    for (int i = 1; i < 15; i++) chk("imp_period", 64'(acc_t[i] - acc_t[i-1]), 64'(17));

    // Backpressure holds data and blocks both input ports
    rst_pulse();
    wr_coef(4'd0, 16'd1);
    m_tready = 1'b0;
    send(16'd5, 1'b0);
    n = 0;
    while (!m_vld[0] && n < 200) begin
      @(negedge clk);
      n++;
    end
    for (int k = 0; k < 10; k++) begin
      chk("bp_vld", 64'(m_vld[0]), 64'(1));
      chk("bp_data", 64'(d32[0]), 64'(5));
      chk("bp_srdy", 64'(s_rdy[0]), 64'(0));
      chk("bp_crdy", 64'(c_rdy[0]), 64'(0));
      @(negedge clk);
    end
    m_tready = 1'b1;
    @(negedge clk);
    chk("bp_done_vld", 64'(m_vld[0]), 64'(0));
    chk("bp_done_srdy", 64'(s_rdy[0]), 64'(1));

    // Saturation vs wrap at OUT_W=16, sticky set and cleared
    rst_pulse();
    wr_coef(4'd0, 16'h7FFF);
    send(16'h7FFF, 1'b0);
    recv();
    chk("sat_data", 64'(g_sat), 64'h7FFF);
    chk("sat_sticky", 64'(sticky[1]), 64'(1));
    chk("wrap_data", 64'(g_trn), 64'h0001);
    chk("wrap_sticky", 64'(sticky[2]), 64'(0));
    chk("full_data", 64'(g_main), 64'h3FFF0001);
    chk("full_sticky", 64'(sticky[0]), 64'(0));
    sat_clr = 1'b1;
    @(negedge clk);
    sat_clr = 1'b0;
    chk("sat_cleared", 64'(sticky[1]), 64'(0));

    // Rounding at SHIFT=15: 0xC000 -> 2 rounded, 1 truncated
    rst_pulse();
    wr_coef(4'd0, 16'h4000);
    send(16'd3, 1'b0);
    recv();
    chk("rnd_on", 64'(g_rnd), 64'(2));
    chk("rnd_off", 64'(g_rnf), 64'(1));
    chk("rnd_acc", 64'(g_main), 64'hC000);

    // Coefficient write protocol
    rst_pulse();
    wr_coef(4'd0, 16'd1);
    send(16'd4, 1'b0);
    chk("cw_busy", 64'(c_rdy[0]), 64'(0));
    coef_we = 1'b1; coef_addr = 4'd1; coef_wdata = 16'd9;
    @(negedge clk);
    coef_we = 1'b0;
    recv();
    chk("cw_first", 64'(g_main), 64'(4));
    wr_coef(4'd15, 16'd5);
    coef_we = 1'b1; coef_addr = 4'd0; coef_wdata = 16'd7;
    send(16'd2, 1'b0);
    coef_we = 1'b0;
    recv();
    chk("cw_same_edge", 64'(g_main), 64'(14));

    // tlast follows its own sample
    rst_pulse();
    wr_coef(4'd0, 16'd1);
    for (int i = 0; i < 4; i++) begin
      send(16'(i + 1), (i == 3));
      recv();
      chk("frame_data", 64'(g_main), 64'(i + 1));
      chk("frame_last", 64'(g_last), 64'(i == 3));
    end

    // Reset while an output is pending
    m_tready = 1'b0;
    send(16'd9, 1'b1);
    n = 0;
    while (!m_vld[0] && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("pre_rst_vld", 64'(m_vld[0]), 64'(1));
    rst_n = 1'b0;
    #1;
    chk("mid_rst_vld", 64'(m_vld[0]), 64'(0));
    chk("mid_rst_data", 64'(d32[0]), 64'(0));
    chk("mid_rst_last", 64'(m_lst[0]), 64'(0));
    chk("mid_rst_srdy", 64'(s_rdy[0]), 64'(1));
    chk("mid_rst_crdy", 64'(c_rdy[0]), 64'(1));
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    send(16'd9, 1'b0);
    recv();
    chk("post_rst_coef", 64'(g_main), 64'(0));
    chk("post_rst_last", 64'(g_last), 64'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
